// File: rtl/lsb_queue_if.sv
// Issue, broadcast, commit, memory and result signals of the load/store queue.
interface lsb_queue_if #(
  parameter int unsigned ROB_WIDTH = 4,
  parameter int unsigned NUM_CDB   = 2
);
  // Decoder issue
  logic                          issue_valid;
  logic                          issue_is_store;
  logic [2:0]                    issue_funct3;
  logic [31:0]                   issue_imm;
  logic [31:0]                   issue_base;
  logic [31:0]                   issue_data;
  logic                          issue_base_dep;
  logic                          issue_data_dep;
  logic [ROB_WIDTH-1:0]          issue_base_rob;
  logic [ROB_WIDTH-1:0]          issue_data_rob;
  logic [ROB_WIDTH-1:0]          issue_rob_id;
  logic                          full;
  // Result broadcast channels
  logic [NUM_CDB-1:0]            cdb_valid;
  logic [NUM_CDB*ROB_WIDTH-1:0]  cdb_rob_id;
  logic [NUM_CDB*32-1:0]         cdb_value;
  // RoB control
  logic                          rob_clear;
  logic [ROB_WIDTH-1:0]          rob_head_id;
  // Memory controller
  logic                          mem_req;
  logic                          mem_we;
  logic [31:0]                   mem_addr;
  logic [31:0]                   mem_wdata;
  logic [1:0]                    mem_size;
  logic                          mem_done;
  logic [31:0]                   mem_rdata;
  // Result output
  logic                          out_valid;
  logic [ROB_WIDTH-1:0]          out_rob_id;
  logic [31:0]                   out_value;

  // Queue side
  modport slave (
    input  issue_valid, issue_is_store, issue_funct3, issue_imm, issue_base, issue_data,
    input  issue_base_dep, issue_data_dep, issue_base_rob, issue_data_rob, issue_rob_id,
    output full,
    input  cdb_valid, cdb_rob_id, cdb_value,
    input  rob_clear, rob_head_id,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_size,
    input  mem_done, mem_rdata,
    output out_valid, out_rob_id, out_value
  );

  // Environment side
  modport master (
    output issue_valid, issue_is_store, issue_funct3, issue_imm, issue_base, issue_data,
    output issue_base_dep, issue_data_dep, issue_base_rob, issue_data_rob, issue_rob_id,
    input  full,
    output cdb_valid, cdb_rob_id, cdb_value,
    output rob_clear, rob_head_id,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_size,
    output mem_done, mem_rdata,
    input  out_valid, out_rob_id, out_value
  );
endinterface

// File: rtl/lsb_queue.sv
// In-order load/store queue: buffers memory ops, snoops broadcasts for operands,
// issues one access at a time from the head and reports results.
module lsb_queue #(
  parameter int unsigned DEPTH_WIDTH = 3,
  parameter int unsigned ROB_WIDTH   = 4,
  parameter int unsigned NUM_CDB     = 2
) (
  input logic       clk,
  input logic       rst,
  input logic       rdy,
  lsb_queue_if.slave bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] DepthCnt = (DEPTH_WIDTH + 1)'(DEPTH);

  typedef struct packed {
    logic                 valid;
    logic                 is_store;
    logic [2:0]           funct3;
    logic [31:0]          imm;
    logic [31:0]          base;
    logic [31:0]          data;
    logic                 base_dep;
    logic                 data_dep;
    logic [ROB_WIDTH-1:0] base_rob;
    logic [ROB_WIDTH-1:0] data_rob;
    logic [ROB_WIDTH-1:0] rob_id;
  } entry_t;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  entry_t                 ent_q [DEPTH];
  entry_t                 ent_d [DEPTH];
  logic [DEPTH_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [DEPTH_WIDTH:0]   count_q, count_d;
  state_e                 state_q, state_d;
  logic                   discard_q, discard_d;
  logic [2:0]             cur_funct3_q, cur_funct3_d;
  logic [ROB_WIDTH-1:0]   cur_rob_q, cur_rob_d;
  logic                   mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]            mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [1:0]             mem_size_q, mem_size_d;
  logic                   out_valid_q, out_valid_d;
  logic [ROB_WIDTH-1:0]   out_rob_id_q, out_rob_id_d;
  logic [31:0]            out_value_q, out_value_d;

  entry_t head_ent;
  logic   full, launch, done, deq, enq;
  logic [32:0] byp_base, byp_data;

  // Lowest channel wins: iterate downwards so channel 0 is applied last.
  function automatic logic [32:0] snoop(input logic [ROB_WIDTH-1:0]         rob,
                                        input logic [NUM_CDB-1:0]           v,
                                        input logic [NUM_CDB*ROB_WIDTH-1:0] ids,
                                        input logic [NUM_CDB*32-1:0]        vals);
    logic [32:0] r;
    r = '0;
    for (int k = int'(NUM_CDB) - 1; k >= 0; k--) begin
      if (v[k] && ids[k*ROB_WIDTH +: ROB_WIDTH] == rob) r = {1'b1, vals[k*32 +: 32]};
    end
    return r;
  endfunction

  assign head_ent = ent_q[head_q];
  assign full     = (count_q == DepthCnt);
  assign launch   = (state_q == StIdle) && head_ent.valid && !head_ent.base_dep &&
                    (!head_ent.is_store ||
                     (!head_ent.data_dep && head_ent.rob_id == bus.rob_head_id)) &&
                    !bus.rob_clear;
  assign done     = (state_q == StWait) && bus.mem_done;
  // A flushed access has already lost its entry, so it never dequeues.
  assign deq      = done && !discard_q && !bus.rob_clear;
  assign enq      = bus.issue_valid && !full && !bus.rob_clear;

  assign byp_base = snoop(bus.issue_base_rob, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
  assign byp_data = snoop(bus.issue_data_rob, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);

  // State register and all other flops; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      state_q      <= StIdle;
      discard_q    <= 1'b0;
      cur_funct3_q <= '0;
      cur_rob_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_size_q   <= '0;
      out_valid_q  <= 1'b0;
      out_rob_id_q <= '0;
      out_value_q  <= '0;
    end else if (rdy) begin
      ent_q        <= ent_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      state_q      <= state_d;
      discard_q    <= discard_d;
      cur_funct3_q <= cur_funct3_d;
      cur_rob_q    <= cur_rob_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_size_q   <= mem_size_d;
      out_valid_q  <= out_valid_d;
      out_rob_id_q <= out_rob_id_d;
      out_value_q  <= out_value_d;
    end
  end

  // Next FSM state: one outstanding access at a time.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (launch) state_d = StWait;
      StWait:  if (bus.mem_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Queue storage: snoop, flush, dequeue, enqueue with same-cycle bypass.
  always_comb begin
    logic [32:0] hit;
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    hit     = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ent_q[i].valid && ent_q[i].base_dep) begin
        hit = snoop(ent_q[i].base_rob, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
        if (hit[32]) begin
          ent_d[i].base     = hit[31:0];
          ent_d[i].base_dep = 1'b0;
        end
      end
      if (ent_q[i].valid && ent_q[i].data_dep) begin
        hit = snoop(ent_q[i].data_rob, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
        if (hit[32]) begin
          ent_d[i].data     = hit[31:0];
          ent_d[i].data_dep = 1'b0;
        end
      end
    end
    if (bus.rob_clear) begin
      for (int i = 0; i < int'(DEPTH); i++) ent_d[i].valid = 1'b0;
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (deq) begin
        ent_d[head_q].valid = 1'b0;
        head_d = head_q + 1'b1;
      end
      if (enq) begin
        ent_d[tail_q].valid    = 1'b1;
        ent_d[tail_q].is_store = bus.issue_is_store;
        ent_d[tail_q].funct3   = bus.issue_funct3;
        ent_d[tail_q].imm      = bus.issue_imm;
        ent_d[tail_q].base_rob = bus.issue_base_rob;
        ent_d[tail_q].data_rob = bus.issue_data_rob;
        ent_d[tail_q].rob_id   = bus.issue_rob_id;
        ent_d[tail_q].base_dep = bus.issue_base_dep && !byp_base[32];
        ent_d[tail_q].base     = (bus.issue_base_dep && byp_base[32]) ? byp_base[31:0]
                                                                     : bus.issue_base;
        ent_d[tail_q].data_dep = bus.issue_data_dep && !byp_data[32];
        ent_d[tail_q].data     = (bus.issue_data_dep && byp_data[32]) ? byp_data[31:0]
                                                                     : bus.issue_data;
        tail_d = tail_q + 1'b1;
      end
      unique case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Memory request and result outputs.
  always_comb begin
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_size_d   = mem_size_q;
    cur_funct3_d = cur_funct3_q;
    cur_rob_d    = cur_rob_q;
    out_valid_d  = 1'b0;
    out_rob_id_d = out_rob_id_q;
    out_value_d  = out_value_q;
    discard_d    = (state_q == StWait) && !bus.mem_done && (discard_q || bus.rob_clear);
    if (launch) begin
      mem_req_d    = 1'b1;
      mem_we_d     = head_ent.is_store;
      mem_addr_d   = head_ent.base + head_ent.imm;
      mem_wdata_d  = head_ent.data;
      mem_size_d   = head_ent.funct3[1:0];
      // Latched because a post-flush enqueue may reuse the head slot.
      cur_funct3_d = head_ent.funct3;
      cur_rob_d    = head_ent.rob_id;
    end
    if (done) begin
      mem_req_d = 1'b0;
      if (!discard_q && !bus.rob_clear) begin
        out_valid_d  = 1'b1;
        out_rob_id_d = cur_rob_q;
        if (mem_we_q) begin
          out_value_d = '0;
        end else begin
          case (cur_funct3_q)
            3'b000:  out_value_d = {{24{bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
            3'b001:  out_value_d = {{16{bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
            3'b100:  out_value_d = {24'h0, bus.mem_rdata[7:0]};
            3'b101:  out_value_d = {16'h0, bus.mem_rdata[15:0]};
            default: out_value_d = bus.mem_rdata;
          endcase
        end
      end
    end
  end

  assign bus.full       = full;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_size   = mem_size_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_rob_id = out_rob_id_q;
  assign bus.out_value  = out_value_q;

endmodule

// File: tb/tb_lsb_queue.sv
// Directed bench for lsb_queue: table of load cases plus hand-written multi-cycle sequences.
module tb_lsb_queue;
  logic clk = 1'b0;
  logic rst;
  logic rdy;

  always #5 clk = ~clk;

  lsb_queue_if #(.ROB_WIDTH(4), .NUM_CDB(2)) bus ();

  lsb_queue #(.DEPTH_WIDTH(3), .ROB_WIDTH(4), .NUM_CDB(2)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] base;
    logic [31:0] imm;
    logic [3:0]  rob;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [1:0]  exp_size;
    logic [31:0] exp_val;
  } vec_t;

  vec_t tbl [7];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.issue_valid    = 1'b0;
    bus.issue_is_store = 1'b0;
    bus.issue_funct3   = 3'b0;
    bus.issue_imm      = '0;
    bus.issue_base     = '0;
    bus.issue_data     = '0;
    bus.issue_base_dep = 1'b0;
    bus.issue_data_dep = 1'b0;
    bus.issue_base_rob = '0;
    bus.issue_data_rob = '0;
    bus.issue_rob_id   = '0;
    bus.cdb_valid      = '0;
    bus.cdb_rob_id     = '0;
    bus.cdb_value      = '0;
    bus.rob_clear      = 1'b0;
    bus.rob_head_id    = '0;
    bus.mem_done       = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  task automatic do_issue(input logic st, input logic [2:0] f3, input logic [31:0] imm,
                          input logic [31:0] base, input logic [31:0] data, input logic bdep,
                          input logic [3:0] brob, input logic [3:0] rob);
    bus.issue_valid    = 1'b1;
    bus.issue_is_store = st;
    bus.issue_funct3   = f3;
    bus.issue_imm      = imm;
    bus.issue_base     = base;
    bus.issue_data     = data;
    bus.issue_base_dep = bdep;
    bus.issue_base_rob = brob;
    bus.issue_data_dep = 1'b0;
    bus.issue_rob_id   = rob;
    tick();
    bus.issue_valid    = 1'b0;
    bus.issue_base_dep = 1'b0;
  endtask

  // Bounded wait for a request; an expired bound shows up as a failed check.
  task automatic wait_req(input string name);
    int n = 0;
    while (!bus.mem_req && n < 30) begin
      tick();
      n++;
    end
    chk({name, " req"}, {31'b0, bus.mem_req}, 32'd1);
  endtask

  task automatic finish_mem(input logic [31:0] rdata);
    bus.mem_done  = 1'b1;
    bus.mem_rdata = rdata;
    tick();
    bus.mem_done  = 1'b0;
  endtask

  task automatic count_reqs(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.mem_req) seen++;
      tick();
    end
  endtask

  initial begin
    int seen;
    tbl[0] = '{3'b010, 32'h0000_0100, 32'h0000_0004, 4'd3, 32'hDEAD_BEEF, 32'h0000_0104, 2'd2,
               32'hDEAD_BEEF};
    tbl[1] = '{3'b000, 32'h0000_0200, 32'h0000_0000, 4'd4, 32'h0000_0080, 32'h0000_0200, 2'd0,
               32'hFFFF_FF80};
    tbl[2] = '{3'b100, 32'h0000_0200, 32'h0000_0001, 4'd5, 32'h0000_0080, 32'h0000_0201, 2'd0,
               32'h0000_0080};
    tbl[3] = '{3'b001, 32'h0000_0300, 32'h0000_0002, 4'd6, 32'h1234_8001, 32'h0000_0302, 2'd1,
               32'hFFFF_8001};
    tbl[4] = '{3'b101, 32'h0000_0300, 32'h0000_0002, 4'd7, 32'h1234_8001, 32'h0000_0302, 2'd1,
               32'h0000_8001};
    tbl[5] = '{3'b010, 32'hFFFF_FFFC, 32'h0000_0008, 4'd8, 32'h0123_4567, 32'h0000_0004, 2'd2,
               32'h0123_4567};
    tbl[6] = '{3'b000, 32'h0000_1000, 32'hFFFF_FFFF, 4'd9, 32'h1234_567F, 32'h0000_0FFF, 2'd0,
               32'h0000_007F};

    clear_inputs();
    rdy = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst mem_we", {31'b0, bus.mem_we}, 32'd0);
    chk("rst out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst mem_addr", bus.mem_addr, 32'd0);
    chk("rst mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst mem_size", {30'b0, bus.mem_size}, 32'd0);
    chk("rst out_rob_id", {28'b0, bus.out_rob_id}, 32'd0);
    chk("rst out_value", bus.out_value, 32'd0);
    chk("rst full", {31'b0, bus.full}, 32'd0);

    // Load vectors: address generation, size and extension
    for (int i = 0; i < 7; i++) begin
      do_issue(1'b0, tbl[i].f3, tbl[i].imm, tbl[i].base, 32'h0, 1'b0, 4'd0, tbl[i].rob);
      wait_req($sformatf("vec%0d", i));
      chk($sformatf("vec%0d addr", i), bus.mem_addr, tbl[i].exp_addr);
      chk($sformatf("vec%0d size", i), {30'b0, bus.mem_size}, {30'b0, tbl[i].exp_size});
      chk($sformatf("vec%0d we", i), {31'b0, bus.mem_we}, 32'd0);
      finish_mem(tbl[i].rdata);
      chk($sformatf("vec%0d out_valid", i), {31'b0, bus.out_valid}, 32'd1);
      chk($sformatf("vec%0d out_rob", i), {28'b0, bus.out_rob_id}, {28'b0, tbl[i].rob});
      chk($sformatf("vec%0d out_value", i), bus.out_value, tbl[i].exp_val);
      tick();
      chk($sformatf("vec%0d pulse", i), {31'b0, bus.out_valid}, 32'd0);
    end

    // Store held until it reaches the RoB head
    bus.rob_head_id = 4'd2;
    do_issue(1'b1, 3'b010, 32'h8, 32'h40, 32'hCAFE_F00D, 1'b0, 4'd0, 4'd5);
    count_reqs(10, seen);
    chk("store gated", seen, 32'd0);
    bus.rob_head_id = 4'd5;
    tick();
    chk("store req", {31'b0, bus.mem_req}, 32'd1);
    chk("store we", {31'b0, bus.mem_we}, 32'd1);
    chk("store addr", bus.mem_addr, 32'h48);
    chk("store wdata", bus.mem_wdata, 32'hCAFE_F00D);
    finish_mem(32'h1234_5678);
    chk("store out_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("store out_rob", {28'b0, bus.out_rob_id}, 32'd5);
    chk("store out_value", bus.out_value, 32'd0);
    tick();

    // Wakeup from channel 1 after enqueue
    do_issue(1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 1'b1, 4'd7, 4'd1);
    count_reqs(3, seen);
    chk("dep blocks", seen, 32'd0);
    bus.cdb_valid  = 2'b10;
    bus.cdb_rob_id = {4'd7, 4'd0};
    bus.cdb_value  = {32'h200, 32'h0};
    tick();
    bus.cdb_valid = '0;
    wait_req("wakeup");
    chk("wakeup addr", bus.mem_addr, 32'h200);
    finish_mem(32'h11);
    chk("wakeup out_rob", {28'b0, bus.out_rob_id}, 32'd1);
    tick();

    // Broadcast in the enqueue cycle
    bus.cdb_valid  = 2'b10;
    bus.cdb_rob_id = {4'd7, 4'd0};
    bus.cdb_value  = {32'h200, 32'h0};
    do_issue(1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 1'b1, 4'd7, 4'd2);
    bus.cdb_valid = '0;
    wait_req("bypass");
    chk("bypass addr", bus.mem_addr, 32'h200);
    finish_mem(32'h22);
    chk("bypass out_value", bus.out_value, 32'h22);
    tick();

    // Fill to full, ignored ninth issue, in-order drain, wrap
    for (int i = 0; i < 8; i++) begin
      do_issue(1'b0, 3'b010, 32'(i * 4), 32'h0, 32'h0, 1'b1, 4'd15, 4'(i));
    end
    chk("full set", {31'b0, bus.full}, 32'd1);
    do_issue(1'b0, 3'b010, 32'h0, 32'h5000, 32'h0, 1'b0, 4'd0, 4'd9);
    chk("full held", {31'b0, bus.full}, 32'd1);
    bus.cdb_valid  = 2'b01;
    bus.cdb_rob_id = {4'd0, 4'd15};
    bus.cdb_value  = {32'h0, 32'h1000};
    tick();
    bus.cdb_valid = '0;
    for (int i = 0; i < 8; i++) begin
      wait_req($sformatf("drain%0d", i));
      chk($sformatf("drain%0d addr", i), bus.mem_addr, 32'h1000 + 32'(i * 4));
      finish_mem(32'h100 + 32'(i));
      chk($sformatf("drain%0d rob", i), {28'b0, bus.out_rob_id}, 32'(i));
      chk($sformatf("drain%0d value", i), bus.out_value, 32'h100 + 32'(i));
    end
    tick();
    chk("full clear", {31'b0, bus.full}, 32'd0);
    count_reqs(5, seen);
    chk("ninth ignored", seen, 32'd0);
    for (int i = 0; i < 3; i++) begin
      do_issue(1'b0, 3'b010, 32'(i * 4), 32'h2000, 32'h0, 1'b0, 4'd0, 4'(10 + i));
    end
    for (int i = 0; i < 3; i++) begin
      wait_req($sformatf("wrap%0d", i));
      chk($sformatf("wrap%0d addr", i), bus.mem_addr, 32'h2000 + 32'(i * 4));
      finish_mem(32'h300 + 32'(i));
      chk($sformatf("wrap%0d rob", i), {28'b0, bus.out_rob_id}, 32'(10 + i));
    end
    tick();

    // Flush during an in-flight load
    do_issue(1'b0, 3'b010, 32'h0, 32'h300, 32'h0, 1'b0, 4'd0, 4'd4);
    wait_req("flush load");
    bus.rob_clear = 1'b1;
    tick();
    bus.rob_clear = 1'b0;
    chk("flush req held", {31'b0, bus.mem_req}, 32'd1);
    chk("flush full", {31'b0, bus.full}, 32'd0);
    tick();
    finish_mem(32'hAAAA_5555);
    chk("flush no out", {31'b0, bus.out_valid}, 32'd0);
    chk("flush req drop", {31'b0, bus.mem_req}, 32'd0);
    do_issue(1'b0, 3'b010, 32'h0, 32'h400, 32'h0, 1'b0, 4'd0, 4'd6);
    wait_req("post flush");
    chk("post flush addr", bus.mem_addr, 32'h400);
    finish_mem(32'h66);
    chk("post flush rob", {28'b0, bus.out_rob_id}, 32'd6);
    chk("post flush value", bus.out_value, 32'h66);
    tick();

    // Flush of queued waiting entries: later broadcast must not revive them
    do_issue(1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 1'b1, 4'd12, 4'd1);
    do_issue(1'b0, 3'b010, 32'h4, 32'h0, 32'h0, 1'b1, 4'd12, 4'd2);
    bus.rob_clear = 1'b1;
    tick();
    bus.rob_clear  = 1'b0;
    bus.cdb_valid  = 2'b01;
    bus.cdb_rob_id = {4'd0, 4'd12};
    bus.cdb_value  = {32'h0, 32'h700};
    tick();
    bus.cdb_valid = '0;
    count_reqs(5, seen);
    chk("flushed queue idle", seen, 32'd0);

    // Flush during an in-flight store
    bus.rob_head_id = 4'd9;
    do_issue(1'b1, 3'b000, 32'h0, 32'h500, 32'h77, 1'b0, 4'd0, 4'd9);
    wait_req("flush store");
    chk("flush store we", {31'b0, bus.mem_we}, 32'd1);
    bus.rob_clear = 1'b1;
    tick();
    bus.rob_clear = 1'b0;
    finish_mem(32'h0);
    chk("flush store no out", {31'b0, bus.out_valid}, 32'd0);
    tick();

    // rdy low: mem_done ignored, state frozen
    do_issue(1'b0, 3'b010, 32'h0, 32'h600, 32'h0, 1'b0, 4'd0, 4'd11);
    wait_req("rdy");
    rdy = 1'b0;
    finish_mem(32'h1);
    chk("rdy req held", {31'b0, bus.mem_req}, 32'd1);
    chk("rdy no out", {31'b0, bus.out_valid}, 32'd0);
    rdy = 1'b1;
    tick();
    chk("rdy still waiting", {31'b0, bus.mem_req}, 32'd1);
    finish_mem(32'h99);
    chk("rdy out_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("rdy out_value", bus.out_value, 32'h99);
    tick();

    // Reset mid-access
    do_issue(1'b0, 3'b010, 32'h0, 32'h800, 32'h0, 1'b0, 4'd0, 4'd13);
    wait_req("rst mid");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst mid req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst mid addr", bus.mem_addr, 32'd0);
    do_issue(1'b0, 3'b010, 32'h8, 32'h900, 32'h0, 1'b0, 4'd0, 4'd14);
    wait_req("after rst");
    chk("after rst addr", bus.mem_addr, 32'h908);
    finish_mem(32'h5A);
    chk("after rst rob", {28'b0, bus.out_rob_id}, 32'd14);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsb_queue.md
Name: lsb_queue

Overview:
- Parametrised in-order load/store queue for the Tomasulo RV32I core; sits between Decoder/RoB and the memory controller.
- Buffers memory instructions in program order and captures operands from N result broadcast channels.
- Issues one memory access at a time from the queue head and broadcasts load results (and store completions) back to RoB/RS.
- Adds over the previous LSB: configurable depth, ROB id width and broadcast channel count, address generation, RoB-head-gated stores, byte/half sign handling, and full flush.

Parameters:
DEPTH_WIDTH, 3, log2 of queue entries (DEPTH = 2**DEPTH_WIDTH)
ROB_WIDTH, 4, width of a RoB id
NUM_CDB, 2, number of result broadcast channels snooped

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; low = freeze all state, outputs hold
issue_valid  in  1  enqueue request from Decoder
issue_is_store  in  1  1 = store, 0 = load
issue_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
issue_imm  in  32  sign-extended offset
issue_base, issue_data  in  32 each  rs1 / rs2 values
issue_base_dep, issue_data_dep  in  1 each  operand not yet available
issue_base_rob, issue_data_rob  in  ROB_WIDTH each  producer RoB id
issue_rob_id  in  ROB_WIDTH  RoB id of this instruction
full  out  1  queue holds DEPTH entries
cdb_valid  in  NUM_CDB  per-channel broadcast valid
cdb_rob_id  in  NUM_CDB*ROB_WIDTH  flattened, channel k at [k*ROB_WIDTH +: ROB_WIDTH]
cdb_value  in  NUM_CDB*32  flattened, channel k at [k*32 +: 32]
rob_clear  in  1  misprediction flush
rob_head_id  in  ROB_WIDTH  RoB id at commit head
mem_req  out  1  memory access request, level
mem_we  out  1  1 = write
mem_addr  out  32  byte address
mem_wdata  out  32  store data, right-aligned
mem_size  out  2  0 = byte, 1 = half, 2 = word
mem_done  in  1  one-cycle completion pulse
mem_rdata  in  32  raw read data, right-aligned, valid with mem_done
out_valid  out  1  one-cycle result pulse
out_rob_id  out  ROB_WIDTH  RoB id of result
out_value  out  32  load value (0 for store)

Behaviour:
- Reset: head = tail = count = 0, all entries invalid, state IDLE; mem_req, mem_we, out_valid = 0; mem_addr, mem_wdata, mem_size, out_rob_id, out_value = 0; full = 0.
- rdy = 0: no state change; outputs hold. mem_done is not sampled while rdy = 0.
- Enqueue: when issue_valid and !full, write the entry at tail, then tail++ (mod DEPTH) and count++.
- full is derived from the registered count only. An issue_valid arriving while full is ignored, even if a dequeue happens in the same cycle.
- Snoop (every cycle, every valid entry, every channel k): if dep set and cdb_valid[k] and the producer id matches, capture the value and clear dep.
- Enqueue-cycle bypass: an incoming operand whose producer is broadcast in the same cycle is stored as ready with the broadcast value.
- Multiple channels matching the same id carry identical values; the lowest k wins.
- State machine:
  - IDLE -> WAIT when the head entry is valid, base is ready, data is ready (stores only), and for stores head rob_id == rob_head_id.
  - On that transition: mem_addr = base + imm (mod 2^32); mem_size = funct3[1:0]; mem_we = is_store; mem_wdata = data; mem_req = 1.
  - WAIT: mem_req and all request fields held stable until mem_done.
  - On mem_done: mem_req = 0, the head entry is dequeued (head++, count--), out_valid pulses next cycle, return to IDLE. Earliest next request is the following cycle.
- Load data: LB/LH sign-extend mem_rdata[7:0] / [15:0]; LBU/LHU zero-extend; LW passes through. Store completion gives out_value = 0.
- Simultaneous enqueue and dequeue: count unchanged; head and tail both advance.
- Wrap-around: head and tail are DEPTH_WIDTH bits and wrap naturally; count is DEPTH_WIDTH+1 bits.
- rob_clear (takes priority over enqueue in the same cycle):
  - All entries are invalidated; head = tail, count = 0.
  - In-flight load: state stays WAIT until mem_done, the result is discarded (no out_valid), then IDLE.
  - In-flight store: already committed, so it completes normally and its out_valid is suppressed. Its entry is already considered removed.
- rst mid-access: everything returns to reset values immediately. The memory controller is reset by the same rst.

Test Plan:
- Load word, operands ready: enqueue LW base=0x100, imm=4, rob 3 -> mem_req with addr 0x104, size 2, we 0; mem_done with rdata 0xDEADBEEF -> out_valid, rob 3, value 0xDEADBEEF.
- Sign/zero extend: LB and then LBU, each with rdata 0x00000080 -> out_value 0xFFFFFF80 for LB, 0x00000080 for LBU.
- Store gating: enqueue SW rob 5 with operands ready and rob_head_id = 2 -> no mem_req for 10 cycles; set rob_head_id = 5 -> mem_req with we 1 on the next edge.
- Dependency wakeup on channel 1 (NUM_CDB = 2): LW base dep on rob 7; cdb_valid = 2'b10 with rob 7, value 0x200, imm 0 -> request addr 0x200. Repeat with the broadcast in the enqueue cycle -> same result.
- Full/wrap: with DEPTH = 8, enqueue 8 entries -> full = 1; a 9th issue is ignored. Drain all 8 -> results in program order; then enqueue 3 more and check tail wraps correctly.
- Flush mid-load: in WAIT, pulse rob_clear -> count = 0; mem_done 2 cycles later produces no out_valid; a new issue after the flush executes normally.
